// File: rtl/code_onehot_display.sv
// rtl/code_onehot_display.sv - buffered {en,code} samples replayed as one-hot LEDs and a 7-segment digit
module code_onehot_display #(
  parameter int DEPTH = 4,
  parameter int HOLD  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_en,
  input  logic [2:0]               in_code,
  output logic                     out_valid,
  output logic [7:0]               out_x,
  output logic [6:0]               out_hex,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(DEPTH);
  localparam logic [HW-1:0] HOLD_LOAD  = HW'(HOLD - 1);
  localparam logic [6:0]    HEX_BLANK  = 7'b1111111;
  localparam logic [6:0]    HEX_DASH   = 7'b0111111;

  typedef enum logic {
    IDLE,
    SHOW
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [3:0]      mem [DEPTH];
  logic [AW-1:0]   wptr;
  logic [AW-1:0]   rptr;
  logic [AW:0]     count;
  logic [HW-1:0]   hold_cnt;
  logic            push;
  logic            pop;
  logic            clear;
  logic [3:0]      rd_data;
  logic [7:0]      dec_x;
  logic [6:0]      dec_hex;

  // Full is judged on the registered count alone, so a same-cycle pop never frees a slot early.
  assign in_ready = (count < FULL_COUNT) && !rst;
  assign push     = in_valid && in_ready;
  assign level    = count;
  assign rd_data  = mem[rptr];

  // Decode the head entry into the LED and segment patterns that get loaded on a pop.
  always_comb begin
    dec_x   = 8'h00;
    dec_hex = HEX_DASH;
    if (rd_data[3]) begin
      dec_x = 8'b1 << rd_data[2:0];
      case (rd_data[2:0])
        3'd0:    dec_hex = 7'b1000000;
        3'd1:    dec_hex = 7'b1111001;
        3'd2:    dec_hex = 7'b0100100;
        3'd3:    dec_hex = 7'b0110000;
        3'd4:    dec_hex = 7'b0011001;
        3'd5:    dec_hex = 7'b0010010;
        3'd6:    dec_hex = 7'b0000010;
        default: dec_hex = 7'b1111000;
      endcase
    end
  end

  // Next state: pop whenever the display slot is free and data is waiting; reloads have no gap cycle.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    clear     = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) begin
          pop       = 1'b1;
          state_nxt = SHOW;
        end
      end
      SHOW: begin
        if (hold_cnt == '0) begin
          if (count != '0) begin
            pop = 1'b1;
          end else begin
            clear     = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Sample storage; contents are don't-care until written, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= {in_en, in_code};
    end
  end

  // Pointers wrap naturally; count is kept separately so full and empty never alias.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        wptr <= wptr + 1'b1;
      end
      if (pop) begin
        rptr <= rptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Hold counter: loaded on each pop, counts down to zero while a sample is on display.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt <= '0;
    end else if (pop) begin
      hold_cnt <= HOLD_LOAD;
    end else if (state == SHOW && hold_cnt != '0) begin
      hold_cnt <= hold_cnt - 1'b1;
    end
  end

  // Display registers: load on pop, blank when the display goes idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_x     <= 8'h00;
      out_hex   <= HEX_BLANK;
    end else if (pop) begin
      out_valid <= 1'b1;
      out_x     <= dec_x;
      out_hex   <= dec_hex;
    end else if (clear) begin
      out_valid <= 1'b0;
      out_x     <= 8'h00;
      out_hex   <= HEX_BLANK;
    end
  end

endmodule

// File: doc/code_onehot_display.md
Name: code_onehot_display

Overview:
- Decode-side counterpart of the priority-encoder path. Accepts {enable, 3-bit code} samples over a valid/ready handshake and buffers them in a small FIFO.
- Replays each sample as a one-hot 8-bit LED pattern plus an active-low 7-segment digit.
- Each sample is held for a fixed number of cycles so a human can see it on the board.
- Sits between encoder/control logic and the LED/seven-segment pins.

Parameters:
- DEPTH, 4, FIFO entries. Must be a power of two and >= 2.
- HOLD, 4, display cycles per sample. Must be >= 1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  producer has a sample.
- in_ready  output  1  FIFO can accept a sample.
- in_en  input  1  sample enable bit. 0 means a "no code" sample.
- in_code  input  3  code to decode.
- out_valid  output  1  a sample is currently being displayed.
- out_x  output  8  one-hot decode of the displayed code.
- out_hex  output  7  active-low segments, bit order {g,f,e,d,c,b,a}.
- level  output  clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset:
  - Asynchronous; takes effect immediately when rst rises.
  - FIFO count, read and write pointers, and hold counter go to 0. State goes to IDLE.
  - Outputs: out_valid=0, out_x=0, out_hex=7'b1111111 (blank), level=0. in_ready=0 while rst=1.
  - Reset mid-display or with a partly filled FIFO discards all stored samples. There is no residual output after release.
- Input side:
  - in_ready = (count < DEPTH) and not rst.
  - A push happens on a rising edge with in_valid & in_ready. It stores {in_en, in_code} at wptr, and wptr increments modulo DEPTH.
  - When full, in_ready=0. A push is never accepted on a full FIFO, even if a pop occurs in the same cycle.
  - in_valid with in_ready=0 is ignored; the producer must hold it.
- Output state machine, two states:
  - IDLE: outputs are at their reset values. On an edge with count>0, pop the rptr entry, load the display registers, set the hold counter to HOLD-1, and go to SHOW.
  - SHOW:
    - The hold counter decrements each edge.
    - On an edge where the counter is 0 and count>0, pop the next entry and reload to HOLD-1 with no gap cycle. The state stays SHOW.
    - On an edge where the counter is 0 and count=0, go to IDLE and return outputs to reset values.
- Display registers, all outputs registered:
  - en=1: out_x = 8'b1 << code. out_hex digit table: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000.
  - en=0: out_x=0 and out_hex=7'b0111111 (dash). The sample still occupies HOLD cycles.
  - out_valid=1 throughout SHOW.
- Latency: a sample pushed into an empty FIFO in IDLE at edge N appears on the outputs after edge N+1. Each sample is shown for exactly HOLD consecutive cycles.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Pointer wrap: rptr and wptr are clog2(DEPTH) bits wide and wrap naturally. count is tracked separately, so full and empty are unambiguous.
- level equals count, registered.

Test Plan:
- Reset release, then push {1,3'd5} in one cycle with HOLD=4 -> after the next edge out_x=8'b00100000, out_hex=0010010, out_valid=1 for exactly 4 cycles; then out_valid=0, out_x=0, out_hex=1111111.
- Push 3,0,7 back-to-back -> outputs show 8'h08/0110000, then 8'h01/1000000, then 8'h80/1111000, each for 4 cycles with no gap; level goes 1,2,then drains to 0.
- Hold in_valid for 6 samples with DEPTH=4 while in_ready is observed -> at most 4 samples buffered beyond the one displayed; in_ready=0 when level=4; no sample lost or duplicated; order preserved across pointer wrap.
- Push {0,3'd6} -> out_valid=1, out_x=0, out_hex=0111111 for 4 cycles.
- Assert rst asynchronously mid-SHOW with level=3 -> outputs go immediately to reset values and level=0; after release, the first new sample displays correctly with no stale data.
- HOLD=1 and a push every cycle -> each sample is displayed for exactly 1 cycle; the FIFO never fills; a push and pop in the same cycle keeps level constant at 1.
